// File: rtl/ram_pkg.sv
// Shared types and width helpers for the sram_bank memory slice.
package ram_pkg;

    localparam int unsigned BYTE_W = 8;

    // Sweep/serve controller states.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Response flags; the data-width-dependent payload is attached in sram_bank.
    typedef struct packed {
        logic valid;
        logic err;
    } rsp_flags_t;

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

    // Byte-offset width; a one-byte word has no offset bits.
    function automatic int unsigned off_width(input int unsigned data_width);
        return (data_width / BYTE_W > 1) ? $clog2(data_width / BYTE_W) : 0;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage with per-byte write enables, one async read port and one write port.
// The write port is shared between the clear sweep and the request path.
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4096,
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned BE_W      = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk_i,
    input  logic                  clr_en_i,
    input  logic [IDX_W-1:0]      clr_idx_i,
    input  logic                  req_we_i,
    input  logic [BE_W-1:0]       req_be_i,
    input  logic [IDX_W-1:0]      req_idx_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [BE_W-1:0]       wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    // Write mux: the clear sweep owns the port while it runs.
    always_comb begin
        wr_en   = req_we_i;
        wr_idx  = req_idx_i;
        wr_be   = req_be_i;
        wr_data = req_wdata_i;
        if (clr_en_i) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_i;
            wr_be   = '1;
            wr_data = '0;
        end
    end

    // Byte-granular storage update.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) begin
                    mem_q[wr_idx][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata_o = mem_q[req_idx_i];

endmodule

// File: rtl/sram_bank.sv
// Single-port word RAM with valid/ready request and registered response channels.
// Define RAM_CLEAR_EN to zero all words with a sweep after every reset.
module sram_bank
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4096,
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned BE_W      = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [BE_W-1:0]       req_be_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);

    localparam int unsigned OFF_W = off_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BE_W - 1);

    typedef struct packed {
        rsp_flags_t            flags;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    state_t                state_q, state_d;
    rsp_t                  rsp_q, rsp_d;
    logic                  accept;
    logic                  addr_err;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  clr_en;
    logic [IDX_W-1:0]      clr_idx;

`ifdef RAM_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Sweep counter; restarts from word 0 on every reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clr_en  = (state_q == ST_CLEAR);
    assign clr_idx = cnt_q;
`else
    localparam state_t RESET_STATE = ST_READY;
    assign clr_en  = 1'b0;
    assign clr_idx = '0;
`endif

    // State and response registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RESET_STATE;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next-state: leave CLEAR once the last word has been written.
    always_comb begin
        state_d = state_q;
`ifdef RAM_CLEAR_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef RAM_CLEAR_EN
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
`else
                state_d = ST_READY;
`endif
            end
            default: state_d = ST_READY;
        endcase
    end

    // Request decode; rst_i gating keeps ready low while reset is held.
    always_comb begin
        busy_o      = clr_en;
        req_ready_o = rst_i && (state_q == ST_READY) && (!rsp_q.flags.valid || rsp_ready_i);
        accept      = req_valid_i && req_ready_o;
        req_idx     = req_addr_i[OFF_W +: IDX_W];
        addr_err    = ((req_addr_i & OFF_MASK) != '0)
                    || ((req_addr_i >> (OFF_W + IDX_W)) != '0);
    end

    // Response register: load on accept, clear on consume, otherwise hold.
    always_comb begin
        rsp_d = rsp_q;
        if (accept) begin
            rsp_d.flags.valid = 1'b1;
            rsp_d.flags.err   = addr_err;
            rsp_d.rdata       = (!req_we_i && !addr_err) ? arr_rdata : '0;
        end else if (rsp_ready_i) begin
            rsp_d = '0;
        end
    end

    assign rsp_valid_o = rsp_q.flags.valid;
    assign rsp_err_o   = rsp_q.flags.err;
    assign rsp_rdata_o = rsp_q.rdata;

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk_i       (clk_i),
        .clr_en_i    (clr_en),
        .clr_idx_i   (clr_idx),
        .req_we_i    (accept && req_we_i && !addr_err),
        .req_be_i    (req_be_i),
        .req_idx_i   (req_idx),
        .req_wdata_i (req_wdata_i),
        .rdata_o     (arr_rdata)
    );

endmodule

// File: tb/tb_sram_bank.sv
// Directed scoreboard bench for sram_bank (DATA_WIDTH=32, DEPTH=16); honours RAM_CLEAR_EN.
`timescale 1ns/1ps
module tb_sram_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16;
`ifdef RAM_CLEAR_EN
    localparam int EXP_SWEEP = 16;
`else
    localparam int EXP_SWEEP = 0;
`endif

    logic          clk_i       = 1'b0;
    logic          rst_i       = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_we_i    = 1'b0;
    logic [3:0]    req_be_i    = '0;
    logic [AW-1:0] req_addr_i  = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          rsp_ready_i = 1'b1;
    logic          req_ready_o;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          busy_o;

    sram_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        string         tag;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          sb_q[$];
    int            rsp_cyc_q[$];
    logic [DW-1:0] mdl [DEPTH];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumed responses are compared against the scoreboard in issue order.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i && rsp_valid_o && rsp_ready_i) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rsp: observed rdata %h expected no response", rsp_rdata_o);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.tag, "_rdata"}, rsp_rdata_o, e.rdata);
                check({e.tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
                rsp_cyc_q.push_back(cyc);
            end
        end
    end

    function automatic exp_t model_req(input string tag, input logic we, input logic [3:0] be,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        exp_t       e;
        logic [3:0] idx;
        e.tag   = tag;
        e.err   = (addr[1:0] != 2'b00) || (addr[31:6] != 26'd0);
        e.rdata = '0;
        idx     = addr[5:2];
        if (!e.err) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mdl[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end else begin
                e.rdata = mdl[idx];
            end
        end
        return e;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_be_i    = be;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        while (!req_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL %s_accept: observed no accept expected accept within 50 cycles", tag);
        end
        sb_q.push_back(model_req(tag, we, be, addr, wdata));
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic sweep_check(input string tag);
        int n   = 0;
        int bad = 0;
        while (busy_o === 1'b1 && n < 100) begin
            if (req_ready_o !== 1'b0) bad++;
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(EXP_SWEEP));
        check({tag, "_ready_while_busy"}, 32'(bad), 32'd0);
        check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
        check({tag, "_ready_after"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected simulation end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;

        // Reset values.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);

        // 1: sweep after reset release.
        rst_i = 1'b1;
        #1;
        sweep_check("t1");
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        do_req("t1_rd3c", 1'b0, 4'hF, 32'h3C, 32'h0);
        drain("t1");
`endif

        // 2: full write, byte-lane write, read back; back-to-back responses.
        rsp_cyc_q.delete();
        do_req("t2_wr", 1'b1, 4'hF, 32'h08, 32'hDEADBEEF);
        do_req("t2_wrb", 1'b1, 4'h1, 32'h08, 32'h000000AA);
        do_req("t2_rd", 1'b0, 4'h0, 32'h08, 32'h0);
        drain("t2");
        check("t2_rsp_count", 32'(rsp_cyc_q.size()), 32'd3);
        if (rsp_cyc_q.size() == 3) begin
            check("t2_gap01", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd1);
            check("t2_gap12", 32'(rsp_cyc_q[2] - rsp_cyc_q[1]), 32'd1);
        end

        // 3: misaligned read and out-of-range write (aliases word 0 if not blocked).
        do_req("t3_wr0", 1'b1, 4'hF, 32'h00, 32'h12345678);
        do_req("t3_rd_mis", 1'b0, 4'hF, 32'h0A, 32'h0);
        do_req("t3_wr_oor", 1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
        do_req("t3_rd0", 1'b0, 4'hF, 32'h00, 32'h0);
        drain("t3");

        // 4: response backpressure, then consume and accept on the same edge.
        rsp_ready_i = 1'b0;
        do_req("t4_rd", 1'b0, 4'h0, 32'h08, 32'h0);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_be_i    = 4'h0;
        req_addr_i  = 32'h00;
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(rsp_valid_o), 32'd1);
            check("t4_hold_rdata", rsp_rdata_o, mdl[2]);
            check("t4_hold_ready", 32'(req_ready_o), 32'd0);
            @(posedge clk_i); #1;
        end
        rsp_ready_i = 1'b1;
        #1;
        check("t4_resume_ready", 32'(req_ready_o), 32'd1);
        sb_q.push_back(model_req("t4_b2b", 1'b0, 4'h0, 32'h00, 32'h0));
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("t4_b2b_valid", 32'(rsp_valid_o), 32'd1);
        check("t4_b2b_rdata", rsp_rdata_o, mdl[0]);
        drain("t4");

        // 5: reset with a response pending, then reset again mid-sweep.
        rsp_ready_i = 1'b0;
        do_req("t5_rd", 1'b0, 4'h0, 32'h08, 32'h0);
        check("t5_pending", 32'(rsp_valid_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("t5_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("t5_rst_rdata", rsp_rdata_o, 32'd0);
        check("t5_rst_ready", 32'(req_ready_o), 32'd0);
        sb_q.delete();
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("t5_mid_busy", 32'(busy_o), 32'(EXP_SWEEP != 0));
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        sweep_check("t5");
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        do_req("t5_rd8", 1'b0, 4'h0, 32'h08, 32'h0);
`else
        for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;
`endif

        // 6: write then read word 1 after reset.
        do_req("t6_wr", 1'b1, 4'hF, 32'h04, 32'hA5A55A5A);
        do_req("t6_rd", 1'b0, 4'h0, 32'h04, 32'h0);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
